// File: rtl/fifo_sram16.sv
// 32x16 single-clock FIFO: a simple dual-port SRAM array plus a pointer/count controller.
// Overflow and underflow are absorbed silently; occupancy is tracked by count, never by pointer equality.

module fifo_sram16_mem #(
  parameter int DW = 16,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write: a read and a write to the same slot return the old contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

module fifo_sram16 #(
  parameter int DW = 16,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr,
  input  logic          rd,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          wa;
  logic          ra;

  assign empty = (count == '0);
  assign full  = (count == DEPTH);
  // A pop in the same cycle frees a slot, so a write to a full FIFO is allowed alongside a read.
  assign wa    = wr & (~full | rd);
  assign ra    = rd & ~empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wa) wptr <= wptr + 1'b1;
      if (ra) rptr <= rptr + 1'b1;
      case ({wa, ra})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  fifo_sram16_mem #(.DW(DW), .AW(AW)) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wa),
    .waddr (wptr),
    .wdata (din),
    .re    (ra),
    .raddr (rptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_fifo_sram16.sv
// Directed bench for fifo_sram16: inputs change on the falling edge, outputs sampled 1ns after the rising edge.

module tb_fifo_sram16;

  logic        clk;
  logic        rstn;
  logic        wr;
  logic        rd;
  logic [15:0] din;
  logic [15:0] dout;

  int checks = 0;
  int errors = 0;

  fifo_sram16 dut (
    .clk  (clk),
    .rstn (rstn),
    .wr   (wr),
    .rd   (rd),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [15:0] d);
    @(negedge clk);
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    cyc(1'b1, 1'b0, d);
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] exp);
    cyc(1'b0, 1'b1, 16'h0);
    chk(tag, dout, exp);
  endtask

  initial begin
    rstn = 1'b0;
    wr   = 1'b0;
    rd   = 1'b0;
    din  = 16'h0;
    #12;
    chk("reset_dout", dout, 16'h0000);
    chk("reset_count", 16'(dut.count), 16'd0);
    @(negedge clk);
    rstn = 1'b1;

    // basic two-entry write/read
    push(16'haa55);
    push(16'hff00);
    pop_chk("basic_rd0", 16'haa55);
    pop_chk("basic_rd1", 16'hff00);
    chk("basic_empty", 16'(dut.count), 16'd0);

    // fill, overflow drop, drain, underflow hold
    for (int i = 0; i < 32; i++) push(16'(i));
    chk("fill_count", 16'(dut.count), 16'd32);
    push(16'h0099);
    chk("ovf_count", 16'(dut.count), 16'd32);
    for (int i = 0; i < 32; i++) pop_chk("drain", 16'(i));
    pop_chk("underflow_hold", 16'h001f);
    chk("drain_count", 16'(dut.count), 16'd0);

    // full, partial read, overflow burst
    for (int i = 0; i < 32; i++) push(16'(i));
    for (int i = 0; i < 3; i++) pop_chk("part_rd", 16'(i));
    for (int i = 0; i < 40; i++) push(16'(i));
    chk("burst_count", 16'(dut.count), 16'd32);
    for (int i = 3; i < 32; i++) pop_chk("burst_rd_hi", 16'(i));
    for (int i = 0; i < 3; i++) pop_chk("burst_rd_lo", 16'(i));
    for (int i = 0; i < 48; i++) pop_chk("burst_hold", 16'h0002);

    // write-then-read across pointer wrap
    for (int i = 0; i < 100; i++) begin
      push(16'(16'h0300 + i));
      pop_chk("wrap", 16'(16'h0300 + i));
    end

    // simultaneous strobes on a full FIFO
    for (int i = 0; i < 32; i++) push(16'(16'h0100 + i));
    cyc(1'b1, 1'b1, 16'h1234);
    chk("full_rw_dout", dout, 16'h0100);
    chk("full_rw_count", 16'(dut.count), 16'd32);
    for (int i = 1; i < 32; i++) pop_chk("full_rw_drain", 16'(16'h0100 + i));
    pop_chk("full_rw_last", 16'h1234);

    // simultaneous strobes on an empty FIFO
    cyc(1'b1, 1'b1, 16'h5678);
    chk("empty_rw_dout", dout, 16'h1234);
    chk("empty_rw_count", 16'(dut.count), 16'd1);
    pop_chk("empty_rw_rd", 16'h5678);

    // asynchronous reset mid-cycle with 10 entries stored
    for (int i = 0; i < 11; i++) push(16'(16'h0200 + i));
    pop_chk("pre_rst_rd", 16'h0200);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("arst_dout", dout, 16'h0000);
    chk("arst_count", 16'(dut.count), 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    pop_chk("post_rst_rd", 16'h0000);
    push(16'hbeef);
    pop_chk("post_rst_new", 16'hbeef);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
